// File: rtl/mux_pipe_n.sv
// mux_pipe_n: NIN-lane word mux feeding a 2-entry skid FIFO with an out-of-range select flag.
// Define MUX_PIPE_BYPASS_EN to let a word pass straight through while the buffer is empty.
module mux_pipe_n #(
    parameter int WIDTH = 64,
    parameter int NIN = 4,
    localparam int SELW = $clog2(NIN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NIN*WIDTH-1:0] in,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 sel_err
);
    logic [WIDTH-1:0] mem_q [2];
    logic [1:0]       count_q, count_d;
    logic             wr_q, wr_d, rd_q, rd_d, sel_err_q, sel_err_d;
    logic [WIDTH-1:0] sel_word;
    logic             sel_bad, push, pop, store;

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NIN; k++)
            if (sel == SELW'(k)) sel_word = in[k*WIDTH +: WIDTH];
    end

    // extra bit so NIN itself is representable when NIN is a power of two
    assign sel_bad  = {1'b0, sel} >= (SELW+1)'(NIN);
    assign in_ready = !count_q[1] && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = out_ready && count_q != 2'd0;

`ifdef MUX_PIPE_BYPASS_EN
    assign out_valid = count_q == 2'd0 ? in_valid && !reset : 1'b1;
    assign out_data  = count_q == 2'd0 ? (reset ? '0 : sel_word) : mem_q[rd_q];
    assign store     = push && !(count_q == 2'd0 && out_ready);
`else
    assign out_valid = count_q != 2'd0;
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign store     = push;
`endif

    assign sel_err = sel_err_q;

    always_comb begin
        count_d   = flush ? 2'd0 : count_q + {1'b0, store} - {1'b0, pop};
        wr_d      = flush ? 1'b0 : wr_q ^ store;
        rd_d      = flush ? 1'b0 : rd_q ^ pop;
        sel_err_d = push && sel_bad && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 2'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_ff @(posedge clk)
        if (store && !flush) mem_q[wr_q] <= sel_word;
endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: NIN=4 and NIN=5 instances on shared stimulus, checked against a queue model.
module tb_mux_pipe_n;
    logic         clk = 0, reset = 1, in_valid = 0, out_ready = 0, flush = 0;
    logic [2:0]   sel = 0;
    logic [319:0] in_bus = '0;
    wire  [1:0]   ov, ir, se;
    wire  [63:0]  od0, od1;
    int           n_chk = 0, n_fail = 0;
    logic [63:0]  m [2][2];
    int           mc [2] = '{0, 0};
    bit           merr [2] = '{0, 0};

    mux_pipe_n #(.WIDTH(64), .NIN(4)) u4 (
        .clk(clk), .reset(reset), .in(in_bus[255:0]), .sel(sel[1:0]), .in_valid(in_valid),
        .in_ready(ir[0]), .out_data(od0), .out_valid(ov[0]), .out_ready(out_ready),
        .flush(flush), .sel_err(se[0]));

    mux_pipe_n #(.WIDTH(64), .NIN(5)) u5 (
        .clk(clk), .reset(reset), .in(in_bus), .sel(sel), .in_valid(in_valid),
        .in_ready(ir[1]), .out_data(od1), .out_valid(ov[1]), .out_ready(out_ready),
        .flush(flush), .sel_err(se[1]));

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pick(int i);
        if (i == 0) return in_bus[int'(sel[1:0])*64 +: 64];
        return (sel < 3'd5) ? in_bus[int'(sel)*64 +: 64] : 64'd0;
    endfunction

    function automatic logic exp_v(int i);
`ifdef MUX_PIPE_BYPASS_EN
        return !reset && (mc[i] > 0 || in_valid);
`else
        return !reset && mc[i] > 0;
`endif
    endfunction

    function automatic logic [63:0] exp_d(int i);
        if (reset) return 64'd0;
        if (mc[i] > 0) return m[i][0];
`ifdef MUX_PIPE_BYPASS_EN
        return pick(i);
`else
        return 64'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            mc   = '{0, 0};
            merr = '{0, 0};
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("valid%0d", i), 64'(ov[i]), 64'(exp_v(i)));
            chk($sformatf("ready%0d", i), 64'(ir[i]), 64'(!reset && mc[i] < 2));
            chk($sformatf("data%0d", i), i == 0 ? od0 : od1, exp_d(i));
            chk($sformatf("sel_err%0d", i), 64'(se[i]), 64'(merr[i]));
        end
    end

    always @(posedge clk) begin
        bit rdy, pu, po, byp;
        logic [63:0] w;
        for (int i = 0; i < 2; i++) begin
            rdy = !reset && mc[i] < 2;
            pu  = in_valid && rdy;
            po  = exp_v(i) && out_ready;
            w   = pick(i);
`ifdef MUX_PIPE_BYPASS_EN
            byp = mc[i] == 0 && out_ready;
`else
            byp = 0;
`endif
            if (reset || flush) begin
                mc[i]   = 0;
                merr[i] = 0;
            end else begin
                merr[i] = pu && i == 1 && sel >= 3'd5;
                if (po && mc[i] > 0) begin
                    m[i][0] = m[i][1];
                    mc[i]--;
                end
                if (pu && !byp) begin
                    m[i][mc[i]] = w;
                    mc[i]++;
                end
            end
        end
    end

    initial begin
        #1;
        chk("rst_valid", 64'(ov[0]), 64'd0);
        chk("rst_ready", 64'(ir[0]), 64'd0);
        chk("rst_data", od0, 64'd0);
        chk("rst_err", 64'(se[1]), 64'd0);
        repeat (2) tick();
        reset = 0;
        for (int k = 0; k < 5; k++) in_bus[k*64 +: 64] = 64'h11 * (k + 1);
`ifdef MUX_PIPE_BYPASS_EN
        sel = 1; in_valid = 1; out_ready = 1;
        #1;
        chk("byp_valid", 64'(ov[0]), 64'd1);
        chk("byp_data", od0, 64'h22);
        tick();
        in_valid = 0;
        #1;
        chk("byp_empty", 64'(ov[0]), 64'd0);
        chk("byp_ready", 64'(ir[0]), 64'd1);
`else
        sel = 2; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        chk("r030_valid", 64'(ov[0]), 64'd1);
        chk("r030_data", od0, 64'h33);
        tick();
        chk("r030_drain", 64'(ov[0]), 64'd0);
        out_ready = 0; sel = 0; in_valid = 1; in_bus[63:0] = 64'hA;
        tick();
        chk("r031_ready_a", 64'(ir[0]), 64'd1);
        in_bus[63:0] = 64'hB;
        tick();
        chk("r031_ready_b", 64'(ir[0]), 64'd0);
        in_bus[63:0] = 64'hC;
        tick();
        chk("r031_head_a", od0, 64'hA);
        chk("r031_hold", 64'(ir[0]), 64'd0);
        out_ready = 1;
        tick();
        chk("r031_head_b", od0, 64'hB);
        chk("r031_ready_ret", 64'(ir[0]), 64'd1);
        tick();
        chk("r031_head_c", od0, 64'hC);
        in_valid = 0;
        tick();
        chk("r031_empty", 64'(ov[0]), 64'd0);
        out_ready = 0; sel = 7; in_valid = 1;
        tick();
        in_valid = 0;
        chk("r032_data", od1, 64'd0);
        chk("r032_valid", 64'(ov[1]), 64'd1);
        chk("r032_err", 64'(se[1]), 64'd1);
        chk("r032_lane3", od0, 64'h44);
        chk("r032_noerr4", 64'(se[0]), 64'd0);
        tick();
        chk("r032_pulse", 64'(se[1]), 64'd0);
        sel = 0; in_valid = 1;
        tick();
        chk("r033_full", 64'(ir[1]), 64'd0);
        sel = 7; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("r033_valid", 64'(ov[1]), 64'd0);
        chk("r033_ready", 64'(ir[1]), 64'd1);
        chk("r033_err", 64'(se[1]), 64'd0);
        sel = 0; in_bus[63:0] = 64'h5; in_valid = 1;
        tick();
        in_valid = 0;
        chk("r034_pre", 64'(ov[0]), 64'd1);
        #2 reset = 1;
        #1;
        chk("r034_async", 64'(ov[0]), 64'd0);
        chk("r034_zero", od0, 64'd0);
        @(posedge clk);
        #1 reset = 0;
        in_bus[63:0] = 64'hAB; in_valid = 1;
        tick();
        in_valid = 0;
        chk("r034_valid", 64'(ov[0]), 64'd1);
        chk("r034_data", od0, 64'hAB);
`endif
        repeat (3000) begin
            for (int k = 0; k < 5; k++) in_bus[k*64 +: 64] = {$urandom, $urandom};
            sel       = 3'($urandom_range(0, 7));
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 31) == 0;
            reset     = $urandom_range(0, 299) == 0;
            tick();
        end
        reset = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_pipe_n.md
MUX_PIPE_N -- requirements
Module: mux_pipe_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the data width of each input lane and of the output.
REQ-002 The block SHALL have parameter NIN, default 4, legal range 2..8, meaning the number of input lanes; the derived select width SELW SHALL be ceil(log2(NIN)).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in, input, NIN*WIDTH bits: the flattened lanes, with lane k at bits [k*WIDTH +: WIDTH].
REQ-006 The block SHALL have port sel, input, SELW bits: the lane select, sampled with in_valid.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream data-valid signal.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the selected word at the buffer head.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts this cycle.
REQ-012 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-013 The block SHALL have port sel_err, output, 1 bit: registered one-cycle pulse flagging that an accepted transfer had sel >= NIN.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high at a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 On an input transfer the block SHALL store lane in[sel] into a 2-entry FIFO (skid buffer) in arrival order.
REQ-016 If sel >= NIN, the stored word SHALL be all zeros and sel_err SHALL be high in the following cycle only.
REQ-017 in_ready SHALL equal (count < 2) and not reset; it SHALL be combinational from state only, never from in_valid.
REQ-018 out_valid SHALL equal (count > 0); out_data SHALL be the oldest entry, and all zeros when count == 0.
REQ-019 Latency SHALL be exactly 1 cycle from an input transfer into an empty buffer to out_valid high (non-bypass build).
REQ-020 A simultaneous push and pop at count 1 SHALL leave count at 1, and out_data SHALL show the new word next cycle.
REQ-021 At count 2, in_ready SHALL be 0; a pop SHALL drop count to 1 and expose the second entry.
REQ-022 At count 0, a pop SHALL be impossible (out_valid 0); out_ready is don't-care.
REQ-023 flush SHALL take priority over all other events: the next state SHALL be count 0, and any same-cycle push SHALL be dropped, with no sel_err pulse generated for it.
REQ-024 count SHALL never exceed 2 or underflow, and the FIFO pointers SHALL wrap modulo 2.

Reset
REQ-025 While reset is high, count SHALL be 0, out_valid 0, in_ready 0, out_data all zeros and sel_err 0, asynchronously.
REQ-026 Reset asserted mid-transfer SHALL discard all entries; the first edge after deassertion SHALL accept input normally.

Configuration
REQ-027 The macro MUX_PIPE_BYPASS_EN SHALL control a zero-latency bypass path.
REQ-028 With MUX_PIPE_BYPASS_EN defined and count == 0, out_valid SHALL equal in_valid and out_data SHALL equal the combinationally selected lane; if out_ready is also high, the word SHALL NOT be stored.
REQ-029 Without MUX_PIPE_BYPASS_EN, no combinational path SHALL exist from in, sel or in_valid to any output.

Verification
REQ-030 NIN=4, WIDTH=64: push lane values 0x11, 0x22, 0x33, 0x44 with sel=2 and out_ready=1 -> the next cycle shows out_valid=1 and out_data=0x33.
REQ-031 Hold out_ready=0 and push 3 words (A, B, C) -> in_ready falls after B; raise out_ready -> A then B emerge in order, and C is accepted only once in_ready returns.
REQ-032 NIN=5, push with sel=7 -> out_data=0 for that entry, and sel_err is high for exactly 1 cycle.
REQ-033 With count=2, assert flush together with in_valid=1 -> the next cycle shows count=0, out_valid=0 and sel_err=0.
REQ-034 Assert reset asynchronously between edges with count=1 -> out_valid falls immediately; after release, a push of 0xAB yields out_data=0xAB one cycle later.
REQ-035 With MUX_PIPE_BYPASS_EN defined, empty buffer, out_ready=1 and in_valid=1 with sel=1 -> the same cycle shows out_valid=1 with out_data=lane1, and the next cycle shows count=0.
